// File: rtl/uts_pkg.sv
// Shared types and width helpers for the unit test sequencer.
// The optional per-vector timeout is enabled by defining UTS_TIMEOUT_EN.
package uts_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_NEXT  = 3'd4,
    S_FIN   = 3'd5
  } uts_state_t;

  localparam int ERR_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 256;

  // Index widths never collapse to zero, so single-channel builds stay legal.
  function automatic int ch_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uts_vec_mem.sv
// Per-channel vector store: {stim, exp, mask} entries addressed by {ch, idx},
// synchronous write, combinational read.
module uts_vec_mem #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int CH_W     = 2,
  parameter int IDX_W    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [CH_W-1:0]  wr_ch_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_stim_i,
  input  logic [WIDTH-1:0] wr_exp_i,
  input  logic [WIDTH-1:0] wr_mask_i,
  input  logic [CH_W-1:0]  rd_ch_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [WIDTH-1:0] rd_stim_o,
  output logic [WIDTH-1:0] rd_exp_o,
  output logic [WIDTH-1:0] rd_mask_o
);

  localparam int ENTRIES = CHANNELS * DEPTH;

  logic [3*WIDTH-1:0] mem_q [ENTRIES];

  // Contents are deliberately not reset; they are reloaded before every run.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wr_ch_i, wr_idx_i}] <= {wr_stim_i, wr_exp_i, wr_mask_i};
    end
  end

  assign {rd_stim_o, rd_exp_o, rd_mask_o} = mem_q[{rd_ch_i, rd_idx_i}];

endmodule

// File: rtl/unit_test_sequencer.sv
// On-chip self-checking sequencer: drives stored stimulus to each channel,
// compares masked responses and keeps a pass/fail summary. Macro: UTS_TIMEOUT_EN.
module unit_test_sequencer
  import uts_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int ERR_W    = ERR_W_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF,
  localparam int CH_W    = ch_w(CHANNELS),
  localparam int IDX_W   = idx_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_en,
  input  logic [CH_W-1:0]           load_ch,
  input  logic [IDX_W-1:0]          load_idx,
  input  logic [WIDTH-1:0]          load_stim,
  input  logic [WIDTH-1:0]          load_exp,
  input  logic [WIDTH-1:0]          load_mask,
  input  logic [IDX_W:0]            num_vec,
  input  logic                      start,
  output logic [CHANNELS-1:0]       stim_valid,
  output logic [WIDTH-1:0]          stim_data,
  input  logic [CHANNELS-1:0]       stim_ready,
  input  logic [CHANNELS-1:0]       resp_valid,
  input  logic [CHANNELS*WIDTH-1:0] resp_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ERR_W-1:0]          err_count,
  output logic                      fail_valid,
  output logic [CH_W-1:0]           fail_ch,
  output logic [IDX_W-1:0]          fail_idx,
  output logic                      timeout_flag,
  output logic [2:0]                dbg_state
);

  localparam logic [IDX_W:0]  NVEC_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]  NVEC_ONE = (IDX_W+1)'(1);
  localparam logic [CH_W-1:0] CH_LAST  = CH_W'(CHANNELS-1);

  uts_state_t       state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W:0]   nvec_q, nvec_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [CH_W-1:0]  fch_q, fch_d;
  logic [IDX_W-1:0] fidx_q, fidx_d;
  logic             tmo_q, tmo_d;
  logic             pass_q, pass_d;
  logic             rec_fail;
  logic             tmo_hit;
  logic             mism;

  logic [WIDTH-1:0] m_stim, m_exp, m_mask;

  uts_vec_mem #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DEPTH    (DEPTH),
    .CH_W     (CH_W),
    .IDX_W    (IDX_W)
  ) u_mem (
    .clk_i     (clk),
    .we_i      (load_en && (state_q == S_IDLE)),
    .wr_ch_i   (load_ch),
    .wr_idx_i  (load_idx),
    .wr_stim_i (load_stim),
    .wr_exp_i  (load_exp),
    .wr_mask_i (load_mask),
    .rd_ch_i   (ch_q),
    .rd_idx_i  (idx_q),
    .rd_stim_o (m_stim),
    .rd_exp_o  (m_exp),
    .rd_mask_o (m_mask)
  );

  assign mism = |((resp_q ^ m_exp) & m_mask);

`ifdef UTS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 2);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  // The counter value is the number of ISSUE+WAIT cycles already spent.
  assign tmo_hit = (tmo_cnt_q >= TMO_W'(TIMEOUT - 1));

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_d == S_ISSUE) && (state_q != S_ISSUE)) begin
      tmo_cnt_d = '0;
    end else if ((state_q == S_ISSUE) || (state_q == S_WAIT)) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  // TIMEOUT has no effect in this build; the compare is constant false.
  assign tmo_hit = (TIMEOUT < 0);
`endif

  // Handshakes: a stimulus transfers on a cycle where stim_valid[ch] and
  // stim_ready[ch] are both high; data holds while valid waits for ready.
  // Responses are one-cycle resp_valid[ch] strobes, looked at only in WAIT.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    idx_d    = idx_q;
    nvec_d   = nvec_q;
    resp_d   = resp_q;
    err_d    = err_q;
    fv_d     = fv_q;
    fch_d    = fch_q;
    fidx_d   = fidx_q;
    tmo_d    = tmo_q;
    pass_d   = pass_q;
    rec_fail = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = '0;
          fv_d   = 1'b0;
          fch_d  = '0;
          fidx_d = '0;
          tmo_d  = 1'b0;
          pass_d = 1'b0;
          ch_d   = '0;
          idx_d  = '0;
          nvec_d = (num_vec > NVEC_MAX) ? NVEC_MAX : num_vec;
          if (num_vec == '0) begin
            pass_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (stim_ready[ch_q]) begin
          state_d = S_WAIT;
        end else if (tmo_hit) begin
          rec_fail = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_WAIT: begin
        if (resp_valid[ch_q]) begin
          resp_d  = resp_data[ch_q*WIDTH +: WIDTH];
          state_d = S_CHECK;
        end else if (tmo_hit) begin
          rec_fail = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_NEXT;
        end
      end
      S_CHECK: begin
        rec_fail = mism;
        state_d  = S_NEXT;
      end
      S_NEXT: begin
        if ({1'b0, idx_q} == (nvec_q - NVEC_ONE)) begin
          idx_d = '0;
          if (ch_q == CH_LAST) begin
            pass_d  = (err_q == '0);
            state_d = S_FIN;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = S_ISSUE;
          end
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_ISSUE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Timeouts and compare mismatches share one failure-recording path.
    if (rec_fail) begin
      if (err_q != '1) err_d = err_q + ERR_W'(1);
      if (!fv_q) begin
        fv_d   = 1'b1;
        fch_d  = ch_q;
        fidx_d = idx_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      idx_q   <= '0;
      nvec_q  <= '0;
      resp_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fch_q   <= '0;
      fidx_q  <= '0;
      tmo_q   <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      nvec_q  <= nvec_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fch_q   <= fch_d;
      fidx_q  <= fidx_d;
      tmo_q   <= tmo_d;
      pass_q  <= pass_d;
    end
  end

  assign stim_valid   = (state_q == S_ISSUE) ? (CHANNELS'(1) << ch_q) : '0;
  assign stim_data    = (state_q == S_ISSUE) ? m_stim : '0;
  assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT) ||
                        (state_q == S_CHECK) || (state_q == S_NEXT);
  assign done         = (state_q == S_FIN);
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_valid   = fv_q;
  assign fail_ch      = fch_q;
  assign fail_idx     = fidx_q;
  assign timeout_flag = tmo_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/unit_test_sequencer.md
Name: unit_test_sequencer

Overview:
- Synthesizable, parametrised self-checking test sequencer for the decode system's unit benches.
- Holds per-channel stimulus, expected and mask vectors and drives CHANNELS DUT ports one vector at a time over valid/ready.
- Captures each response, compares it under mask and accumulates a pass/fail summary.
- Replaces per-unit file-driven benches with one reusable on-chip checker usable in simulation and on FPGA.

Parameters:
- WIDTH, 32, stimulus/response/expected data width
- CHANNELS, 4, number of DUT channels sequenced
- DEPTH, 16, vectors stored per channel (power of two)
- ERR_W, 16, error counter width
- TIMEOUT, 256, cycle limit per vector (used only with UTS_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- load_en  in  1  write one vector entry this cycle
- load_ch  in  $clog2(CHANNELS)  channel of entry
- load_idx  in  $clog2(DEPTH)  vector index
- load_stim  in  WIDTH  stimulus word
- load_exp  in  WIDTH  expected response
- load_mask  in  WIDTH  compare mask (1 = bit checked)
- num_vec  in  $clog2(DEPTH)+1  vectors per channel for this run, sampled at start
- start  in  1  begin run (single-cycle pulse)
- stim_valid  out  CHANNELS  one-hot, stimulus offered to channel
- stim_data  out  WIDTH  stimulus word, shared by all channels
- stim_ready  in  CHANNELS  channel accepts stimulus
- resp_valid  in  CHANNELS  channel response valid
- resp_data  in  CHANNELS*WIDTH  flattened responses; channel c at [c*WIDTH +: WIDTH]
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  err_count==0 at last run end
- err_count  out  ERR_W  mismatching vectors, saturating
- fail_valid  out  1  a failure has been recorded
- fail_ch  out  $clog2(CHANNELS)  channel of first failure
- fail_idx  out  $clog2(DEPTH)  vector index of first failure
- timeout_flag  out  1  a vector timed out this run

Behaviour:
- Reset: every output 0, FSM in IDLE. Vector memory contents are not reset.
- FSM states: IDLE, ISSUE, WAIT, CHECK, NEXT, FIN.
- IDLE: on start, clear err_count/fail_*/timeout_flag/pass, latch num_vec, ch=0, idx=0, set busy. If num_vec==0, go to FIN; otherwise go to ISSUE.
- start while busy: ignored.
- load_en: honoured only in IDLE, written in 1 cycle. A load in the same cycle as start is written before the run reads memory.
- ISSUE: stim_valid[ch]=1, stim_data=stim[ch][idx], held stable until stim_ready[ch]. On handshake go to WAIT; stim_valid drops the next cycle.
- WAIT: resp_valid[ch] is sampled only in this state. DUT latency is at least 1 cycle after handshake. On resp_valid[ch], register the channel's response slice and go to CHECK.
- resp_valid on any other channel, or outside WAIT: ignored.
- CHECK: mismatch = |((resp ^ exp[ch][idx]) & mask[ch][idx]).
  - On mismatch, err_count increments, saturating at all-ones.
  - The first mismatch of the run sets fail_valid, fail_ch, fail_idx; later failures do not overwrite them.
- NEXT: idx++. When idx==num_vec-1 before the increment, set idx=0 and ch++. When ch wraps past CHANNELS-1, go to FIN; otherwise go to ISSUE.
- num_vec > DEPTH: clamped to DEPTH.
- FIN: busy=0, done=1 for one cycle, pass=(err_count==0), go to IDLE. Results hold until the next start.
- Latency per vector: ISSUE (>=1) + WAIT (>=1) + CHECK (1) + NEXT (1).
- reset asserted mid-run: immediate return to IDLE, all outputs 0, stim_valid drops asynchronously.

Optional Feature:
- Macro UTS_TIMEOUT_EN.
- Defined:
  - A cycle counter runs through ISSUE+WAIT of each vector and clears on entry to ISSUE.
  - On reaching TIMEOUT the vector is treated as a mismatch (err_count, first-fail capture), timeout_flag is set, and the FSM goes to NEXT.
  - A response arriving in the expiry cycle is accepted, not timed out.
- Not defined: no counter; the FSM waits indefinitely; timeout_flag is tied to 0.

Decomposition:
- Package uts_pkg holds:
  - the state enum uts_state_t;
  - the CH_W/IDX_W width helper functions;
  - the default ERR_W;
  - the TIMEOUT default.
- Sub-module uts_vec_mem: CHANNELS*DEPTH entries of {stim, exp, mask}, with a synchronous write port and a combinational read port addressed by {ch, idx}.

Test Plan:
- Load 2 vectors per channel with resp==exp, mask all-ones, num_vec=2, DUT echo with 1-cycle latency -> 8 handshakes in channel order 0..3, done pulse, pass=1, err_count=0.
- Channel 2 vector 1 returns 0x0000_00F0, expected 0x0000_0000, mask 0x0000_000F -> pass=1. Same case with mask 0x0000_00FF -> err_count=1, fail_ch=2, fail_idx=1.
- Inject mismatches at ch1/idx0 and ch3/idx1 -> err_count=2, fail_ch=1, fail_idx=0.
- stim_ready held low 5 cycles on channel 0 -> stim_valid[0] and stim_data stable all 5 cycles; start pulsed mid-run -> ignored; num_vec=0 -> done in 2 cycles, pass=1.
- reset low during WAIT of ch1 -> all outputs 0 immediately. Restart after reset -> full run passes.
- With UTS_TIMEOUT_EN and TIMEOUT=8, channel 3 never responds -> timeout_flag=1, err_count=num_vec, run completes.
